// File: rtl/btn_pkg.sv
// Shared state and gesture encodings for the button gesture classifier.
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HELD = 3'd2,
      WAIT2     = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   localparam logic [1:0] GEST_NONE   = 2'd0;
   localparam logic [1:0] GEST_SHORT  = 2'd1;
   localparam logic [1:0] GEST_LONG   = 2'd2;
   localparam logic [1:0] GEST_DOUBLE = 2'd3;

endpackage

// File: rtl/button_gesture_edge_detect.sv
// Registers the debounced level and flags its rising and falling edges.
module edge_detect (
   input  logic clk,
   input  logic btn,
   output logic rise,
   output logic fall
);

   logic btn_q;

   // Loads unconditionally, so reset leaves btn_q equal to btn and no edge.
   always_ff @(posedge clk) begin
      btn_q <= btn;
   end

   assign rise = btn & ~btn_q;
   assign fall = ~btn & btn_q;

endmodule

// File: rtl/button_gesture.sv
// Classifies button interactions into short, long and double-click gestures.
module button_gesture
   import btn_pkg::*;
#(
   parameter int LONG_CYCLES   = 1000,
   parameter int DCLICK_CYCLES = 250,
   parameter int CNT_W         = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   output logic       short_press,
   output logic       long_press,
   output logic       double_click,
   output logic       held,
   output logic [1:0] last_gesture,
   output logic [7:0] gesture_cnt
);

   localparam longint CNT_LIM = 64'd1 << CNT_W;
   localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_T = CNT_W'(DCLICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);

   if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2) begin : g_bad_min
      $error("LONG_CYCLES and DCLICK_CYCLES must be >= 2");
   end
   if (CNT_LIM <= longint'(LONG_CYCLES) ||
       CNT_LIM <= longint'(DCLICK_CYCLES)) begin : g_bad_w
      $error("CNT_W too narrow for cycle parameters");
   end

   logic             rise;
   logic             fall;
   state_t           state;
   logic [CNT_W-1:0] timer;

   edge_detect u_edge (
      .clk  (clk),
      .btn  (btn),
      .rise (rise),
      .fall (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         timer        <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_click <= 1'b0;
         held         <= 1'b0;
         last_gesture <= GEST_NONE;
         gesture_cnt  <= 8'd0;
      end else begin
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_click <= 1'b0;
         if (timer != '1) timer <= timer + T_ONE;
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= PRESS1;
                  timer <= T_ONE;
               end
            end
            PRESS1: begin
               if (btn && timer == LONG_T) begin
                  state        <= LONG_HELD;
                  timer        <= T_ONE;
                  long_press   <= 1'b1;
                  held         <= 1'b1;
                  last_gesture <= GEST_LONG;
                  gesture_cnt  <= gesture_cnt + 8'd1;
               end else if (fall) begin
                  state <= WAIT2;
                  timer <= T_ONE;
               end
            end
            LONG_HELD: begin
               if (fall) begin
                  state <= IDLE;
                  timer <= T_ONE;
                  held  <= 1'b0;
               end
            end
            WAIT2: begin
               if (rise) begin
                  state <= PRESS2;
                  timer <= T_ONE;
               end else if (!btn && timer == DCLICK_T) begin
                  state        <= IDLE;
                  timer        <= T_ONE;
                  short_press  <= 1'b1;
                  last_gesture <= GEST_SHORT;
                  gesture_cnt  <= gesture_cnt + 8'd1;
               end
            end
            PRESS2: begin
               // Second press length does not matter; the release completes it.
               if (fall) begin
                  state        <= IDLE;
                  timer        <= T_ONE;
                  double_click <= 1'b1;
                  last_gesture <= GEST_DOUBLE;
                  gesture_cnt  <= gesture_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= T_ONE;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_gesture.sv
// Scoreboard bench for button_gesture with LONG_CYCLES=8, DCLICK_CYCLES=4.
module tb_button_gesture;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn = 1'b0;
   logic       short_press;
   logic       long_press;
   logic       double_click;
   logic       held;
   logic [1:0] last_gesture;
   logic [7:0] gesture_cnt;

   typedef struct {
      int         at;
      logic [1:0] code;
      logic [7:0] cnt;
   } exp_t;

   exp_t       q[$];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] exp_cnt = 8'd0;

   button_gesture #(
      .LONG_CYCLES   (8),
      .DCLICK_CYCLES (4),
      .CNT_W         (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn          (btn),
      .short_press  (short_press),
      .long_press   (long_press),
      .double_click (double_click),
      .held         (held),
      .last_gesture (last_gesture),
      .gesture_cnt  (gesture_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic hold(input logic lvl, input int n);
      btn = lvl;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_g(input int at, input logic [1:0] code);
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.at   = at;
      e.code = code;
      e.cnt  = exp_cnt;
      q.push_back(e);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      hold(btn, n);
      reset = 1'b0;
      exp_cnt = 8'd0;
   endtask

   // Monitor: pops one expectation per observed pulse.
   always @(negedge clk) begin
      int   np;
      int   kind;
      exp_t e;
      np   = int'(short_press) + int'(long_press) + int'(double_click);
      kind = double_click ? 3 : long_press ? 2 : short_press ? 1 : 0;
      if (np != 0) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", kind, 0);
         end else begin
            e = q.pop_front();
            chk("pulse_edge", cyc, e.at);
            chk("pulse_kind", kind, int'(e.code));
            chk("pulse_count_one", np, 1);
            chk("last_gesture", int'(last_gesture), int'(e.code));
            chk("gesture_cnt", int'(gesture_cnt), int'(e.cnt));
         end
      end else if (q.size() > 0 && cyc > q[0].at) begin
         e = q.pop_front();
         chk("missed_pulse_kind", 0, int'(e.code));
      end
   end

   initial begin
      int c;
      do_reset(3);
      chk("rst_short", int'(short_press), 0);
      chk("rst_long", int'(long_press), 0);
      chk("rst_double", int'(double_click), 0);
      chk("rst_held", int'(held), 0);
      chk("rst_last", int'(last_gesture), 0);
      chk("rst_cnt", int'(gesture_cnt), 0);
      hold(1'b0, 2);

      // Short press: 3 high, release, pulse 3 edges after release edge.
      c = cyc;
      expect_g(c + 4 + 3, 2'd1);
      hold(1'b1, 3);
      hold(1'b0, 10);

      // Long press: pulse at 8th high sample, held until release.
      c = cyc;
      expect_g(c + 8, 2'd2);
      hold(1'b1, 5);
      chk("held_before_long", int'(held), 0);
      hold(1'b1, 7);
      chk("held_during_long", int'(held), 1);
      hold(1'b1, 8);
      chk("held_late", int'(held), 1);
      hold(1'b0, 1);
      chk("held_after_release", int'(held), 0);
      hold(1'b0, 9);

      // Boundary: 7 highs is short, 8 highs is long.
      c = cyc;
      expect_g(c + 8 + 3, 2'd1);
      hold(1'b1, 7);
      hold(1'b0, 10);
      c = cyc;
      expect_g(c + 8, 2'd2);
      hold(1'b1, 8);
      hold(1'b0, 10);

      // Double click with gap of 2 lows.
      c = cyc;
      expect_g(c + 7, 2'd3);
      hold(1'b1, 2);
      hold(1'b0, 2);
      hold(1'b1, 2);
      hold(1'b0, 10);
      chk("last_after_double", int'(last_gesture), 3);

      // Gap of 4 lows: two separate shorts.
      c = cyc;
      expect_g(c + 6, 2'd1);
      expect_g(c + 12, 2'd1);
      hold(1'b1, 2);
      hold(1'b0, 4);
      hold(1'b1, 2);
      hold(1'b0, 10);

      // Held through reset release: not a press until re-pressed.
      btn = 1'b1;
      do_reset(2);
      chk("cnt_after_reset", int'(gesture_cnt), 0);
      chk("last_after_reset", int'(last_gesture), 0);
      hold(1'b1, 12);
      hold(1'b0, 10);
      c = cyc;
      expect_g(c + 4 + 3, 2'd1);
      hold(1'b1, 3);
      hold(1'b0, 10);
      chk("cnt_after_repress", int'(gesture_cnt), 1);

      // Reset while waiting for a second press.
      hold(1'b1, 2);
      hold(1'b0, 2);
      do_reset(1);
      hold(1'b0, 10);
      chk("cnt_after_wait2_reset", int'(gesture_cnt), 0);
      chk("last_after_wait2_reset", int'(last_gesture), 0);

      // 256 shorts wrap the counter back to zero.
      for (int k = 0; k < 256; k++) begin
         c = cyc;
         expect_g(c + 6, 2'd1);
         hold(1'b1, 2);
         hold(1'b0, 4);
      end
      hold(1'b0, 6);
      chk("cnt_wrap", int'(gesture_cnt), 0);
      chk("queue_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
